// File: rtl/pwm_dac_pkg.sv
// Shared defaults and config-word field layout for the dithered PWM DAC.
// The encoder helper builds a config word from its duty and pattern fields.
package pwm_dac_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int DITH_N_DEF = 16;
  localparam int CCW_DEF    = CNT_W_DEF + DITH_N_DEF;

  localparam int DUTY_LSB = DITH_N_DEF;
  localparam int PAT_LSB  = 0;

  function automatic logic [CCW_DEF-1:0] encode_cfg(
    input logic [CNT_W_DEF-1:0]  duty,
    input logic [DITH_N_DEF-1:0] pat
  );
    logic [CCW_DEF-1:0] w;
    w = '0;
    w[DUTY_LSB +: CNT_W_DEF] = duty;
    w[PAT_LSB +: DITH_N_DEF] = pat;
    return w;
  endfunction

endpackage

// File: rtl/pwm_frame_cnt.sv
// Period counter (cnt) and dither index (idx) pair. Both clear while disabled,
// so re-enabling always starts a fresh frame at idx 0.
module pwm_frame_cnt #(
  parameter int CNT_W  = 8,
  parameter int DITH_N = 16,
  parameter int IDX_W  = $clog2(DITH_N)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             frame_end_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cnt_max;
  logic             idx_last;

  assign cnt_max  = (cnt_q == {CNT_W{1'b1}});
  assign idx_last = (idx_q == IDX_W'(DITH_N - 1));

  always_comb begin
    cnt_d = '0;
    idx_d = '0;
    if (en_i) begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_max) begin
        idx_d = idx_last ? '0 : idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign idx_o       = idx_q;
  assign frame_end_o = en_i & cnt_max & idx_last;

endmodule

// File: rtl/pwm_dither_dac.sv
// Dithered PWM DAC output stage: captures the config word at frame end and
// compares the period counter against duty plus the per-period dither bit.
module pwm_dither_dac
  import pwm_dac_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DITH_N = DITH_N_DEF,
  parameter int CCW    = CCW_DEF,
  parameter int IDX_W  = $clog2(DITH_N)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic [CCW-1:0]   cfg_i,
  output logic             pwm_o,
  output logic             frame_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              frame_end;

  logic [CNT_W-1:0]  duty_q, duty_d;
  logic [DITH_N-1:0] pat_q, pat_d;
  logic              pwm_q, pwm_d;
  logic              frame_q, frame_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W:0]    thr;

  pwm_frame_cnt #(
    .CNT_W (CNT_W),
    .DITH_N(DITH_N),
    .IDX_W (IDX_W)
  ) u_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (en_i),
    .cnt_o      (cnt),
    .idx_o      (idx),
    .frame_end_o(frame_end)
  );

  // One extra bit keeps duty=max plus a dither bit at 2^CNT_W: high all period.
  assign thr = {1'b0, duty_q} + {{CNT_W{1'b0}}, pat_q[idx]};

  always_comb begin
    duty_d  = duty_q;
    pat_d   = pat_q;
    pwm_d   = 1'b0;
    frame_d = 1'b0;
    idx_d   = '0;
    if (frame_end) begin
      duty_d = cfg_i[CCW-1:DITH_N];
      pat_d  = cfg_i[DITH_N-1:0];
    end
    if (en_i) begin
      pwm_d   = ({1'b0, cnt} < thr);
      frame_d = (cnt == '0) && (idx == '0);
      idx_d   = idx;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      duty_q  <= '0;
      pat_q   <= '0;
      pwm_q   <= 1'b0;
      frame_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      duty_q  <= duty_d;
      pat_q   <= pat_d;
      pwm_q   <= pwm_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
    end
  end

  assign pwm_o   = pwm_q;
  assign frame_o = frame_q;
  assign idx_o   = idx_q;

endmodule

// File: tb/tb_pwm_dither_dac.sv
// Bench for pwm_dither_dac: reference model tracks position within the frame
// as a single integer and derives each output from the duty/dither rules.
module tb_pwm_dither_dac;

  localparam int PERIOD = 256;
  localparam int NPER   = 16;
  localparam int FRAME  = PERIOD * NPER;

  // clock / reset
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [23:0] cfg = '0;
  logic        pwm_o;
  logic        frame_o;
  logic [3:0]  idx_o;

  always #5 clk = ~clk;

  pwm_dither_dac dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .en_i   (en),
    .cfg_i  (cfg),
    .pwm_o  (pwm_o),
    .frame_o(frame_o),
    .idx_o  (idx_o)
  );

  // reference model state
  int          pos = 0;
  logic [7:0]  m_duty = '0;
  logic [15:0] m_pat = '0;

  // scoreboard
  logic [5:0]  exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          fr_active = 0;
  int          fr_len = 0;
  int          fr_high = 0;
  int          fr_target = 0;
  int          fr_snap = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // One clock: predict outputs from inputs present before the edge, then check.
  task automatic step();
    logic       ep, ef;
    logic [3:0] ei;
    logic [5:0] e;
    int         ix, off, thr;
    logic       drop;
    ep = 1'b0; ef = 1'b0; ei = '0; drop = 1'b0;
    if (!rstn || !en) begin
      pos  = 0;
      drop = 1'b1;
      if (!rstn) begin
        m_duty = '0;
        m_pat  = '0;
      end
    end else begin
      ix  = pos / PERIOD;
      off = pos % PERIOD;
      thr = int'(m_duty) + int'(m_pat[ix]);
      ep  = (off < thr);
      ef  = (pos == 0);
      ei  = 4'(ix);
      if (ef) fr_snap = NPER * int'(m_duty) + $countones(m_pat);
      if (pos == FRAME - 1) begin
        m_duty = cfg[23:16];
        m_pat  = cfg[15:0];
      end
      pos = (pos + 1) % FRAME;
    end
    exp_q.push_back({ep, ef, ei});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("pwm", 32'(pwm_o), 32'(e[5]));
    check_val("frame", 32'(frame_o), 32'(e[4]));
    check_val("idx", 32'(idx_o), 32'(e[3:0]));
    if (drop) fr_active = 0;
    if (e[4]) begin
      fr_active = 1;
      fr_len    = 0;
      fr_high   = 0;
      fr_target = fr_snap;
    end
    if (fr_active != 0) begin
      fr_len++;
      fr_high += int'(pwm_o);
      if (fr_len == FRAME) begin
        check_val("frame_high", 32'(fr_high), 32'(fr_target));
        fr_active = 0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset_check();
    rstn = 1'b0;
    #1;
    check_val("rst_pwm", 32'(pwm_o), 32'd0);
    check_val("rst_frame", 32'(frame_o), 32'd0);
    check_val("rst_idx", 32'(idx_o), 32'd0);
    pos = 0; m_duty = '0; m_pat = '0; fr_active = 0;
    run(3);
    rstn = 1'b1;
  endtask

  task automatic run_until_pos(input int target, input string tag);
    int n;
    n = 0;
    while (pos != target && n < 2 * FRAME) begin
      step();
      n++;
    end
    check_val(tag, 32'(pos), 32'(target));
  endtask

  initial begin
    #1;
    check_val("init_pwm", 32'(pwm_o), 32'd0);
    check_val("init_frame", 32'(frame_o), 32'd0);
    check_val("init_idx", 32'(idx_o), 32'd0);
    run(3);
    rstn = 1'b1;

    // 1: all-zero config, output never high
    en = 1'b1; cfg = 24'h000000;
    run(3 * FRAME);

    // 2: full scale, then async reset while the output is high
    cfg = 24'hFFFFFF;
    run(2 * FRAME);
    run(100);
    check_val("pre_rst_pwm_high", 32'(pwm_o), 32'd1);
    async_reset_check();

    // 3: plain 25% duty
    cfg = 24'h400000;
    run(2 * FRAME);

    // 4: alternating dither bits
    cfg = 24'h405555;
    run(2 * FRAME + 10);

    // 5: change config at idx 7 of a running frame
    cfg = 24'h400000;
    run_until_pos(0, "t5_sync");
    run_until_pos(0, "t5_sync2");
    run_until_pos(7 * PERIOD + 10, "t5_idx7");
    cfg = 24'h800000;
    run(FRAME + 20);

    // 6: enable drop for 100 cycles, then resume with held config
    run(300);
    en = 1'b0;
    run(100);
    en = 1'b1;
    run(FRAME + 5);

    // enable falling exactly on the capture cycle: no capture
    cfg = 24'h20F0F0;
    run_until_pos(FRAME - 1, "cap_edge");
    en = 1'b0;
    cfg = 24'hC00001;
    run(5);
    en = 1'b1;
    cfg = 24'h20F0F0;
    run(FRAME + 5);

    // randomized config and enable activity
    for (int k = 0; k < 10; k++) begin
      cfg = 24'($urandom);
      en  = 1'b1;
      run($urandom_range(200, 2000));
      if ($urandom_range(0, 2) == 0) begin
        en = 1'b0;
        run($urandom_range(1, 40));
        en = 1'b1;
      end
    end
    cfg = 24'($urandom);
    run(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_dither_dac.md
Name: pwm_dither_dac

Overview:
- Consumer end of the PWM DAC configuration word, one instance per PWM output pin.
- Takes the 24-bit config word (8-bit duty cycle plus 16-bit dither pattern) from the analog mixed-signal register block.
- Produces a single-bit, dithered pulse-width-modulated output that feeds the external RC-filtered PWM DAC.
- Resolution comes from 2^CNT_W-cycle PWM periods, refined by a 1-cycle duty extension chosen per period from the dither pattern over a frame of DITH_N periods.

Parameters:
- CNT_W, 8: period counter width; PWM period = 2^CNT_W clock cycles.
- DITH_N, 16: periods per dither frame; equals the pattern width.
- CCW, 24: config word width; must equal CNT_W + DITH_N.

Ports:
- clk_i, input, 1: clock.
- rstn_i, input, 1: reset. Asynchronous, active-low.
- en_i, input, 1: run enable.
- cfg_i, input, CCW: config word. [CCW-1:DITH_N] is the duty value; [DITH_N-1:0] is the dither pattern.
- pwm_o, input/output direction is output, 1: PWM output, registered.
- frame_o, output, 1: 1-cycle strobe, coincident with the first pwm_o cycle of each frame.
- idx_o, output, 4 (log2 DITH_N): dither index of the period currently on pwm_o.

Behaviour:
- Reset state (asynchronous, immediate on rstn_i low):
  - pwm_o=0, frame_o=0, idx_o=0.
  - Internal cnt=0, idx=0, duty_r=0, pat_r=0.
- Counters:
  - cnt increments every cycle while en_i=1 and wraps from 2^CNT_W-1 to 0.
  - idx increments when cnt wraps and rolls from DITH_N-1 to 0.
- Config capture:
  - In the last cycle of a frame (cnt=max and idx=DITH_N-1, en_i=1), duty_r and pat_r load from cfg_i.
  - The new value applies to the whole following frame.
  - cfg_i changes mid-frame have no effect until the frame boundary. Worst-case latency is 2^CNT_W·DITH_N cycles.
  - The first frame after reset runs with the reset config (output low).
- Threshold:
  - thr = {1'b0,duty_r} + pat_r[idx], a CNT_W+1-bit unsigned value. No overflow is possible; the maximum is 2^CNT_W.
  - Bit 0 of the pattern applies to period idx=0, LSB first.
- Output:
  - pwm_o <= (cnt < thr), registered, so 1-cycle latency relative to the internal cnt.
  - Each period on pwm_o is high for exactly thr consecutive cycles, starting at the period's first cycle.
  - duty=0 with bit 0: constantly low.
  - duty=max with bit 1: thr=2^CNT_W, constantly high across period boundaries with no glitch.
  - High time per frame = DITH_N·duty + popcount(pattern).
- Strobes:
  - frame_o <= (cnt=0 and idx=0 and en_i), aligned with pwm_o.
  - idx_o is registered alongside pwm_o.
- Enable:
  - en_i=0: synchronously cnt←0, idx←0, pwm_o←0, frame_o←0. duty_r and pat_r hold.
  - Rising en_i starts a fresh frame at idx 0 with the held config.
  - cfg_i is not captured while en_i=0.
- Reset mid-operation: outputs go low immediately and the config is cleared. Operation resumes at a frame start after rstn_i deasserts.
- Simultaneous en_i fall and frame-end capture: enable wins, so there is no capture.

Decomposition:
- Shared package pwm_dac_pkg:
  - CNT_W, DITH_N, CCW defaults.
  - Field offset constants DUTY_LSB=DITH_N and PAT_LSB=0, also used by the config-word encoder.
- One natural sub-module, pwm_frame_cnt: the cnt/idx counter pair with wrap, frame-end and enable-clear logic. The top level holds capture, threshold compare and output registers.

Test Plan:
1. Reset, en_i=1, cfg_i=0x000000 for 3 frames (12288 cycles) -> pwm_o never high; frame_o pulses every 4096 cycles.
2. cfg_i=0xFFFFFF applied before a frame boundary -> from the next frame_o, pwm_o held high for all 4096 cycles of every frame.
3. cfg_i=0x400000 -> every period pwm_o high for exactly 64 cycles then low for 192; 1024 high per frame.
4. cfg_i=0x405555 -> periods with even idx_o high 65 cycles, odd idx_o high 64; 1032 high per frame; the sequence repeats each frame.
5. cfg_i changes 0x400000→0x800000 at idx=7 -> rest of frame stays at 64/period; next frame 128/period, starting exactly at frame_o.
6. Assert rstn_i low mid-period with pwm_o=1 -> pwm_o=0 the same instant, idx_o=0. Separately, en_i low for 100 cycles then high -> pwm_o low while disabled; frame_o pulses 1 cycle after re-enable with the held duty.
